// File: rtl/noc_mesh_router_wh.sv
// ---------------------------------------------------------------------------
// noc_mesh_router_wh
// 5-port wormhole router for an XY-routed 2D mesh. Each input has a FIFO.
// Each output has a round-robin allocator with a packet lock and a single
// output register stage. Port index order: P=0 (local), E=1, W=2, N=3, S=4.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   cur_x, cur_y           this node's mesh coordinates (static after reset)
//   in_tvalid/tready       per-input handshake (5 bits)
//   in_tdata/tdest/tlast   per-input beat, port k at slice k
//   out_tvalid/tready      per-output handshake (5 bits)
//   out_tdata/tdest/tlast  per-output registered beat, port k at slice k
//   out_lock               output is held by a packet that is still in flight
// ---------------------------------------------------------------------------
module noc_mesh_router_wh #(
  parameter  int DATA_W = 64,
  parameter  int DX_W   = 2,
  parameter  int DY_W   = 2,
  parameter  int FIFO_D = 4,
  localparam int DEST_W = DX_W + DY_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DX_W-1:0]     cur_x,
  input  logic [DY_W-1:0]     cur_y,
  input  logic [4:0]          in_tvalid,
  output logic [4:0]          in_tready,
  input  logic [5*DATA_W-1:0] in_tdata,
  input  logic [5*DEST_W-1:0] in_tdest,
  input  logic [4:0]          in_tlast,
  output logic [4:0]          out_tvalid,
  input  logic [4:0]          out_tready,
  output logic [5*DATA_W-1:0] out_tdata,
  output logic [5*DEST_W-1:0] out_tdest,
  output logic [4:0]          out_tlast,
  output logic [4:0]          out_lock
);

  localparam int unsigned NP = 5;
  localparam int unsigned AW = $clog2(FIFO_D);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    PORT_P = 3'd0,
    PORT_E = 3'd1,
    PORT_W = 3'd2,
    PORT_N = 3'd3,
    PORT_S = 3'd4
  } port_e;

  // Input FIFO storage and state
  logic [DATA_W-1:0] mem_data [NP][FIFO_D];
  logic [DEST_W-1:0] mem_dest [NP][FIFO_D];
  logic              mem_last [NP][FIFO_D];
  logic [AW-1:0]     wr_ptr   [NP];
  logic [AW-1:0]     rd_ptr   [NP];
  logic [CW-1:0]     cnt      [NP];
  logic [CW-1:0]     cnt_next [NP];
  logic [NP-1:0]     push;
  logic [NP-1:0]     pop;
  logic [NP-1:0]     empty;

  // FIFO head view and route
  logic [DATA_W-1:0] hd_data [NP];
  logic [DEST_W-1:0] hd_dest [NP];
  logic              hd_last [NP];
  port_e             route   [NP];

  // Allocator state and decisions
  logic [2:0]        owner  [NP];
  logic [2:0]        rr_ptr [NP];
  logic [2:0]        sel    [NP];
  logic [NP-1:0]     req    [NP];
  logic [NP-1:0]     sel_vld;
  logic [NP-1:0]     load;
  logic [2:0]        cand;

  // Head view, XY route and FIFO occupancy update
  always_comb begin
    for (int unsigned i = 0; i < NP; i++) begin
      empty[i]   = (cnt[i] == '0);
      push[i]    = in_tvalid[i] & in_tready[i];
      hd_data[i] = mem_data[i][rd_ptr[i]];
      hd_dest[i] = mem_dest[i][rd_ptr[i]];
      hd_last[i] = mem_last[i][rd_ptr[i]];
      if (hd_dest[i][DX_W-1:0] > cur_x)
        route[i] = PORT_E;
      else if (hd_dest[i][DX_W-1:0] < cur_x)
        route[i] = PORT_W;
      else if (hd_dest[i][DEST_W-1:DX_W] > cur_y)
        route[i] = PORT_S;
      else if (hd_dest[i][DEST_W-1:DX_W] < cur_y)
        route[i] = PORT_N;
      else
        route[i] = PORT_P;
      unique case ({push[i], pop[i]})
        2'b10:   cnt_next[i] = cnt[i] + CW'(1);
        2'b01:   cnt_next[i] = cnt[i] - CW'(1);
        default: cnt_next[i] = cnt[i];
      endcase
    end
  end

  // Per-output allocation. Each input head has a single route, so an input
  // can be selected by at most one output and pops never collide.
  always_comb begin
    pop     = '0;
    sel_vld = '0;
    load    = '0;
    cand    = '0;
    for (int unsigned o = 0; o < NP; o++) begin
      req[o] = '0;
      sel[o] = '0;
    end
    for (int unsigned o = 0; o < NP; o++) begin
      for (int unsigned i = 0; i < NP; i++)
        req[o][i] = !empty[i] && (route[i] == port_e'(o));
      if (out_lock[o]) begin
        if (req[o][owner[o]]) begin
          sel_vld[o] = 1'b1;
          sel[o]     = owner[o];
        end
      end else begin
        for (int unsigned k = 0; k < NP; k++) begin
          cand = 3'((32'(rr_ptr[o]) + k) % NP);
          if (!sel_vld[o] && req[o][cand]) begin
            sel_vld[o] = 1'b1;
            sel[o]     = cand;
          end
        end
      end
      load[o] = sel_vld[o] && (!out_tvalid[o] || out_tready[o]);
      if (load[o])
        pop[sel[o]] = 1'b1;
    end
  end

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge clk) begin
    if (rst) begin
      in_tready <= '0;
      for (int unsigned i = 0; i < NP; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NP; i++) begin
        if (push[i])
          wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])
          rd_ptr[i] <= rd_ptr[i] + AW'(1);
        cnt[i]       <= cnt_next[i];
        in_tready[i] <= (cnt_next[i] != CW'(FIFO_D));
      end
    end
  end

  // FIFO storage carries no reset; occupancy alone defines valid entries
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NP; i++) begin
      if (push[i]) begin
        mem_data[i][wr_ptr[i]] <= in_tdata[i*DATA_W +: DATA_W];
        mem_dest[i][wr_ptr[i]] <= in_tdest[i*DEST_W +: DEST_W];
        mem_last[i][wr_ptr[i]] <= in_tlast[i];
      end
    end
  end

  // Output registers, packet lock and round-robin pointer. A tlast beat
  // leaves the lock clear, so single-beat packets never show out_lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_tvalid <= '0;
      out_tdata  <= '0;
      out_tdest  <= '0;
      out_tlast  <= '0;
      out_lock   <= '0;
      for (int unsigned o = 0; o < NP; o++) begin
        owner[o]  <= '0;
        rr_ptr[o] <= '0;
      end
    end else begin
      for (int unsigned o = 0; o < NP; o++) begin
        if (load[o]) begin
          out_tvalid[o]                 <= 1'b1;
          out_tdata[o*DATA_W +: DATA_W] <= hd_data[sel[o]];
          out_tdest[o*DEST_W +: DEST_W] <= hd_dest[sel[o]];
          out_tlast[o]                  <= hd_last[sel[o]];
          if (hd_last[sel[o]]) begin
            out_lock[o] <= 1'b0;
            rr_ptr[o]   <= (sel[o] == 3'(NP - 1)) ? '0 : sel[o] + 3'd1;
          end else begin
            out_lock[o] <= 1'b1;
            owner[o]    <= sel[o];
          end
        end else if (out_tready[o]) begin
          out_tvalid[o] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/noc_mesh_router_wh.md
Name: noc_mesh_router_wh

Overview:
- Parametrised 5-port wormhole router: the next-generation node for the team's XY-routed 2D mesh NoC.
- Adds several capabilities over the fixed-coordinate single-beat router:
  - configurable per-input FIFO depth;
  - multi-beat packets held on one output until tlast (wormhole lock);
  - fair round-robin output arbitration;
  - node coordinates as runtime ports, so one netlist serves any mesh position.
- Port order: P=0 (local), E=1, W=2, N=3, S=4.

Parameters:
- DATA_W, 64, payload width per beat.
- DX_W, 2, X coordinate width in tdest.
- DY_W, 2, Y coordinate width in tdest.
- FIFO_D, 4, per-input FIFO depth in beats; power of two, >=2.
- DEST_W, DX_W+DY_W, derived; tdest width (not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cur_x  in  DX_W  this node's X; static after reset.
- cur_y  in  DY_W  this node's Y; static after reset.
- in_tvalid  in  5  per-port input valid.
- in_tready  out  5  per-port input ready.
- in_tdata  in  5*DATA_W  port k at [k*DATA_W +: DATA_W].
- in_tdest  in  5*DEST_W  x = [DX_W-1:0], y = [DEST_W-1:DX_W] per slice.
- in_tlast  in  5  last beat of packet.
- out_tvalid  out  5  per-port output valid.
- out_tready  in  5  per-port output ready.
- out_tdata  out  5*DATA_W  output payload.
- out_tdest  out  5*DEST_W  forwarded unchanged.
- out_tlast  out  5  forwarded unchanged.
- out_lock  out  5  output currently owned by an in-flight packet (status).

Behaviour:
- Reset (clk edge with rst=1):
  - all FIFOs empty;
  - in_tready = 0 during reset, 5'h1F the cycle after;
  - out_tvalid = 0, out_lock = 0;
  - all round-robin pointers = 0;
  - out_tdata/tdest/tlast = 0.
  - Reset mid-packet discards all buffered beats and locks; no partial-packet recovery.
- Input side:
  - in_tready[k] = !full[k], registered from FIFO state.
  - No combinational path from out_tready; a pop in the same cycle does not raise tready on a full FIFO.
  - Write when in_tvalid & in_tready.
- Route computation on each FIFO head's tdest (dx, dy):
  - dx > cur_x -> E; dx < cur_x -> W;
  - else dy > cur_y -> S; dy < cur_y -> N;
  - else P.
  - Comparisons unsigned.
  - Y grows southward.
  - No U-turn check; the result is used as computed.
- Per-output allocator:
  - Unlocked: among inputs whose non-empty head routes to this output, grant the first at or after rr_ptr (ascending, wrapping 4->0).
  - Granting sets lock and owner.
  - Locked: only the owner may send.
  - Lock clears and rr_ptr = (owner+1) mod 5 in the cycle the owner's tlast beat moves from FIFO to output register.
  - A single-beat packet (tlast on first beat) locks and unlocks in the same cycle; out_lock stays 0 for it.
  - An input is granted by at most one output (its head has one route), so no input conflict exists.
- Output register:
  - One stage per output.
  - Loads when (!out_tvalid | out_tready) and a granted head exists; pop that FIFO the same cycle.
  - out_tvalid holds with data stable until out_tready.
  - Full throughput: 1 beat/cycle/output with continuous ready.
- Latency: beat accepted at cycle t appears at out_tvalid in cycle t+2 if uncontended (t+1: FIFO head + arbitrate + load).
- Simultaneous push/pop:
  - On a non-empty, non-full FIFO, count is unchanged.
  - On an empty FIFO, push is not bypassed (no cut-through).
- Packets from one input stay in order; no interleaving of packets on an output.

Test Plan:
1. Reset then idle: after rst deassert, in_tready=5'h1F, out_tvalid=0, out_lock=0; hold 10 cycles -> no change.
2. Local-to-east single beat:
   - cur=(1,1); P sends tdest x=2,y=1, tlast=1, tdata=64'hA5 at cycle t.
   - out_tvalid[1]=1 at t+2 with tdata=64'hA5, tlast=1; out_lock[1] stays 0.
3. Routing coverage:
   - cur=(1,1); dests (0,1),(1,0),(1,2),(1,1) from P.
   - Emerge on W, N, S, P respectively with tdest unchanged.
4. Wormhole lock vs contention:
   - W and N both send a 3-beat packet to E in the same cycle (rr_ptr=0).
   - W's 3 beats exit E back-to-back, then N's 3 beats; out_lock[1]=1 during W's beats 2-3.
   - rr_ptr becomes 3 after W's tlast.
5. Round-robin fairness:
   - P, E, W, N continuously send 1-beat packets to S.
   - S output order P,E,W,N,P,E,... with equal counts over 40 beats.
6. Backpressure/full and reset mid-packet:
   - Hold out_tready[1]=0 while P streams to E; accepted beat count = FIFO_D+1 (4 FIFO + 1 output reg), then in_tready[0]=0.
   - Assert rst mid-packet -> next cycle all out_tvalid=0, out_lock=0, FIFOs empty.
